// File: rtl/core_pkg.sv
// Shared RV32I encodings, CSR addresses and datapath helpers.
// Imported by core and core_memory.
package core_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_PRIV = 3'd0;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;

  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

  function automatic logic [31:0] alu(
    input logic [2:0]  f3,
    input logic        alt,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = '0;
    unique case (f3)
      F3_ADD:  r = alt ? a - b : a + b;
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: r = {31'b0, a < b};
      F3_XOR:  r = a ^ b;
      F3_SR:   r = alt ? 32'($signed(a) >>> b[4:0])
                       : a >> b[4:0];
      F3_OR:   r = a | b;
      F3_AND:  r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic t;
    t = 1'b0;
    unique case (f3)
      F3_BEQ:  t = a == b;
      F3_BNE:  t = a != b;
      F3_BLT:  t = $signed(a) < $signed(b);
      F3_BGE:  t = $signed(a) >= $signed(b);
      F3_BLTU: t = a < b;
      F3_BGEU: t = a >= b;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/core_memory.sv
// Unified little-endian byte memory: combinational fetch and
// data read ports, byte-enabled write port on the rising edge.
module core_memory #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  import core_pkg::*;

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] m [0:MEM_BYTES-1];

  function automatic logic [AW-1:0] wrap(input logic [31:0] a);
    logic [31:0] n;
    logic [31:0] t;
    n = MEM_BYTES;
    t = a % n;
    return t[AW-1:0];
  endfunction

  // Both read ports gather four consecutive bytes, wrapping at the top.
  always_comb begin
    fetch_data = '0;
    rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      fetch_data[8*k +: 8] = m[wrap(fetch_addr + 32'(k))];
      rd_data[8*k +: 8] = m[wrap(rd_addr + 32'(k))];
    end
  end

  // Each enabled lane lands at its literal byte address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k])
          m[wrap(wr_addr + 32'(k))] <= wr_data[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/core.sv
// Single-cycle RV32I core with unified memory instance "memory".
// Define CORE_CYCLE_COUNTER_EN to make mcycle/cycle count clocks.
module core #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 65536
) (
  input logic clk,
  input logic rst
);
  import core_pkg::*;

  logic [31:0] pc;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] instr, ld_word;
  logic [6:0]  opc;
  logic [4:0]  rd, r1, r2;
  logic [2:0]  f3;
  logic [11:0] imm12;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] a, b, csr_rd, csr_src;

  logic [31:0] next_pc, rd_val, csr_wval, mem_addr, cause;
  logic        rd_we, csr_we, mem_we, trap, wr_en;
  logic [3:0]  mem_be;

  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign r1    = instr[19:15];
  assign r2    = instr[24:20];
  assign imm12 = instr[31:20];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25],
                  instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20],
                  instr[30:21], 1'b0};
  assign a     = rs[r1];
  assign b     = rs[r2];
  assign wr_en = mem_we & rst;

  core_memory #(.MEM_BYTES(MEM_BYTES)) memory (
    .clk        (clk),
    .fetch_addr (pc),
    .fetch_data (instr),
    .rd_addr    (mem_addr),
    .rd_data    (ld_word),
    .wr_en      (wr_en),
    .wr_be      (mem_be),
    .wr_addr    (mem_addr),
    .wr_data    (b)
  );

  // CSR read view: hart id is constant, cycle aliases mcycle.
  always_comb begin
    csr_rd = csr[imm12];
    if (imm12 == CSR_MHARTID) csr_rd = '0;
`ifdef CORE_CYCLE_COUNTER_EN
    if (imm12 == CSR_CYCLE) csr_rd = csr[CSR_MCYCLE];
`endif
  end

  // Decode and execute the instruction at pc.
  always_comb begin
    next_pc  = pc + 32'd4;
    rd_we    = 1'b0;
    rd_val   = '0;
    mem_we   = 1'b0;
    mem_be   = 4'b0000;
    mem_addr = a + imm_i;
    csr_we   = 1'b0;
    csr_wval = '0;
    trap     = 1'b0;
    cause    = '0;
    csr_src  = f3[2] ? {27'b0, r1} : a;
    unique case (opc)
      OPC_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OPC_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OPC_JAL: begin
        rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        rd_we = 1'b1; rd_val = pc + 32'd4;
        next_pc = (a + imm_i) & ~32'd1;
      end
      OPC_BRANCH:
        if (br_taken(f3, a, b)) next_pc = pc + imm_b;
      OPC_LOAD: begin
        rd_we = 1'b1;
        unique case (f3)
          F3_LB:  rd_val = {{24{ld_word[7]}}, ld_word[7:0]};
          F3_LH:  rd_val = {{16{ld_word[15]}}, ld_word[15:0]};
          F3_LW:  rd_val = ld_word;
          F3_LBU: rd_val = {24'b0, ld_word[7:0]};
          F3_LHU: rd_val = {16'b0, ld_word[15:0]};
          default: rd_we = 1'b0;
        endcase
      end
      OPC_STORE: begin
        mem_addr = a + imm_s;
        mem_we = 1'b1;
        unique case (f3)
          F3_SB:   mem_be = 4'b0001;
          F3_SH:   mem_be = 4'b0011;
          F3_SW:   mem_be = 4'b1111;
          default: mem_we = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        rd_we = 1'b1;
        rd_val = alu(f3, (f3 == F3_SR) & instr[30], a, imm_i);
      end
      OPC_OP: begin
        rd_we = 1'b1;
        rd_val = alu(f3, instr[31:25] == F7_ALT, a, b);
      end
      OPC_SYSTEM:
        if (f3 == F3_PRIV) begin
          unique case (imm12)
            F12_ECALL: begin
              trap = 1'b1; cause = CAUSE_ECALL_M;
              next_pc = csr[CSR_MTVEC] & ~32'd3;
            end
            F12_EBREAK: begin
              trap = 1'b1; cause = CAUSE_BREAKPOINT;
              next_pc = csr[CSR_MTVEC] & ~32'd3;
            end
            F12_MRET: next_pc = csr[CSR_MEPC];
            default: ;
          endcase
        end else begin
          rd_we = 1'b1;
          rd_val = csr_rd;
          unique case (f3[1:0])
            2'b01: begin csr_we = 1'b1; csr_wval = csr_src; end
            2'b10: begin
              csr_we = r1 != 5'd0; csr_wval = csr_rd | csr_src;
            end
            2'b11: begin
              csr_we = r1 != 5'd0; csr_wval = csr_rd & ~csr_src;
            end
            default: rd_we = 1'b0;
          endcase
        end
      default: ;
    endcase
  end

  // Architectural state update; reset clears pc, rs and csr at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= '0;
      for (int i = 0; i < 4096; i++) csr[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
`ifdef CORE_CYCLE_COUNTER_EN
      csr[CSR_MCYCLE] <= csr[CSR_MCYCLE] + 32'd1;
`endif
      if (csr_we) csr[imm12] <= csr_wval;
      if (trap) begin
        csr[CSR_MEPC]   <= pc;
        csr[CSR_MCAUSE] <= cause;
      end
    end
  end

endmodule

// File: tb/tb_core.sv
// Directed-program bench for core: loads small programs into
// memory.m, runs fixed cycle counts, checks architectural state.
module tb_core;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  core dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
    input logic [4:0] s1, input logic [2:0] f3,
    input logic [4:0] d, input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm,
    input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3);
    return {imm[11:5], s2, s1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm,
    input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm,
    input logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3,
    input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  task automatic put(input int adr, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      dut.memory.m[adr + k] = w[8*k +: 8];
  endtask

  task automatic boot();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 512; i++) dut.memory.m[i] = 8'h00;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] acc;
  logic [31:0] w;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    #2;
    acc = '0;
    for (int i = 1; i < 32; i++) acc = acc | dut.rs[i];
    check("reset_pc", dut.pc, 32'h0);
    check("reset_rs", acc, 32'h0);

    // addi, then an asynchronous reset pulse between edges
    boot();
    put(0, enc_i(12'd1, 5'd0, 3'd0, 5'd3, 7'h13));
    go();
    run(1);
    check("addi_rd", dut.rs[3], 32'h1);
    check("addi_pc", dut.pc, 32'h4);
    run(1);
    #2;
    rst = 1'b0;
    #1;
    check("async_pc", dut.pc, 32'h0);
    check("async_rs", dut.rs[3], 32'h0);

    // loads, stores, extension and ALU
    boot();
    put(32'h00, enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13));
    put(32'h04, enc_i(12'h080, 5'd0, 3'd0, 5'd2, 7'h13));
    put(32'h08, enc_s(12'd0, 5'd2, 5'd1, 3'd0));
    put(32'h0c, enc_i(12'd0, 5'd1, 3'd0, 5'd3, 7'h03));
    put(32'h10, enc_i(12'd0, 5'd1, 3'd4, 5'd4, 7'h03));
    put(32'h14, {20'h12345, 5'd5, 7'h37});
    put(32'h18, enc_i(12'h678, 5'd5, 3'd0, 5'd5, 7'h13));
    put(32'h1c, enc_s(12'd4, 5'd5, 5'd1, 3'd2));
    put(32'h20, enc_i(12'd6, 5'd1, 3'd1, 5'd6, 7'h03));
    put(32'h24, enc_i(12'd4, 5'd1, 3'd2, 5'd7, 7'h03));
    put(32'h28, enc_s(12'd4, 5'd2, 5'd1, 3'd1));
    put(32'h2c, enc_i(12'd4, 5'd1, 3'd2, 5'd8, 7'h03));
    put(32'h30, enc_i(12'h404, 5'd3, 3'd5, 5'd9, 7'h13));
    put(32'h34, enc_i(12'h004, 5'd3, 3'd5, 5'd10, 7'h13));
    put(32'h38, enc_r(7'h20, 5'd5, 5'd2, 3'd0, 5'd11));
    put(32'h3c, enc_r(7'h00, 5'd2, 5'd3, 3'd2, 5'd12));
    put(32'h40, enc_r(7'h00, 5'd2, 5'd3, 3'd3, 5'd13));
    go();
    run(17);
    check("lb", dut.rs[3], 32'hFFFFFF80);
    check("lbu", dut.rs[4], 32'h00000080);
    check("lui_addi", dut.rs[5], 32'h12345678);
    check("lh_hi", dut.rs[6], 32'h00001234);
    check("lw", dut.rs[7], 32'h12345678);
    check("sh_lw", dut.rs[8], 32'h12340080);
    check("srai", dut.rs[9], 32'hFFFFFFF8);
    check("srli", dut.rs[10], 32'h0FFFFFF8);
    check("sub", dut.rs[11], 32'hEDCBAA08);
    check("slt", dut.rs[12], 32'h1);
    check("sltu", dut.rs[13], 32'h0);
    check("sb_byte", {24'b0, dut.memory.m[32'h100]}, 32'h80);
    check("ls_pc", dut.pc, 32'h44);

    // branches and jumps
    boot();
    put(32'h00, enc_i(12'd5, 5'd0, 3'd0, 5'd5, 7'h13));
    put(32'h04, enc_i(12'd5, 5'd0, 3'd0, 5'd6, 7'h13));
    put(32'h08, enc_b(13'h20, 5'd6, 5'd5, 3'd1));
    put(32'h0c, enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));
    put(32'h10, enc_j(21'h40, 5'd1));
    put(32'h50, enc_b(13'h10, 5'd6, 5'd5, 3'd5));
    put(32'h60, enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h67));
    go();
    run(3);
    check("bne_nt_pc", dut.pc, 32'h0c);
    run(2);
    check("jal_pc", dut.pc, 32'h50);
    check("jal_link", dut.rs[1], 32'h14);
    check("x0_zero", dut.rs[0], 32'h0);
    run(1);
    check("bge_t_pc", dut.pc, 32'h60);
    run(1);
    check("jalr_pc", dut.pc, 32'h14);
    check("jalr_link", dut.rs[2], 32'h64);

    // trap entry, CSR ops, mret
    boot();
    put(32'h00, enc_i(12'h040, 5'd0, 3'd0, 5'd5, 7'h13));
    put(32'h04, enc_i(12'h305, 5'd5, 3'd1, 5'd0, 7'h73));
    put(32'h08, enc_j(21'h18, 5'd0));
    put(32'h20, 32'h00000073);
    put(32'h40, enc_i(12'h341, 5'd0, 3'd2, 5'd7, 7'h73));
    put(32'h44, enc_i(12'h340, 5'd5, 3'd5, 5'd0, 7'h73));
    put(32'h48, enc_i(12'h340, 5'd1, 3'd7, 5'd9, 7'h73));
    put(32'h4c, enc_i(12'hF14, 5'd0, 3'd2, 5'd10, 7'h73));
    put(32'h50, 32'h30200073);
    go();
    run(4);
    check("ecall_pc", dut.pc, 32'h40);
    check("mepc", dut.csr[12'h341], 32'h20);
    check("mcause", dut.csr[12'h342], 32'd11);
    check("mtvec", dut.csr[12'h305], 32'h40);
    run(5);
    check("mret_pc", dut.pc, 32'h20);
    check("csrrs_rd", dut.rs[7], 32'h20);
    check("csrrs_nowr", dut.csr[12'h341], 32'h20);
    check("csrrci_rd", dut.rs[9], 32'h5);
    check("csrrci_wr", dut.csr[12'h340], 32'h4);
    check("mhartid", dut.rs[10], 32'h0);

    // self-modifying code through fence.i
    boot();
    check("csr_reset", dut.csr[12'h305], 32'h0);
    put(32'h00, {20'h00100, 5'd1, 7'h37});
    put(32'h04, enc_i(12'h193, 5'd1, 3'd0, 5'd1, 7'h13));
    put(32'h08, enc_s(12'h030, 5'd1, 5'd0, 3'd2));
    put(32'h0c, 32'h0000100F);
    put(32'h10, enc_j(21'h20, 5'd0));
    put(32'h30, 32'h00000013);
    go();
    run(4);
    w = {dut.memory.m[32'h33], dut.memory.m[32'h32],
         dut.memory.m[32'h31], dut.memory.m[32'h30]};
    check("smc_word", w, 32'h00100193);
    check("fence_pc", dut.pc, 32'h10);
    run(2);
    check("smc_rd", dut.rs[3], 32'h1);
    check("smc_pc", dut.pc, 32'h34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
